fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register. Feeds the decode stage `instrIn`, `nextPcIn` and `memStall`.
- Owns the PC and runs a stalling instruction-memory handshake (single-cycle hit or multi-cycle miss).
- Applies branch redirects, hazard holds and halt.
- Output bubbles are NOP 16'h0800 with nextPcOut 16'h0000, so decode suppresses halt on bubbles.

---
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register and a stalling imem handshake.
// Optional FETCH_STALL_CNT_EN adds a saturating stallCnt output.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazStall,
    input  logic        doBranch,
    input  logic [15:0] branchPc,
    input  logic        haltIn,
    input  logic [15:0] imemData,
    input  logic        imemDone,
    input  logic        imemStall,
    output logic [15:0] imemAddr,
    output logic        imemRd,
    output logic [15:0] instrOut,
    output logic [15:0] nextPcOut,
    output logic        memStall,
    output logic        err
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stallCnt
`endif
);

    typedef enum logic [2:0] {S_FETCH, S_WAIT, S_SKID, S_DRAIN, S_HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] npc_q, npc_d;
    logic [15:0] skid_q, skid_d;
    logic        err_q, err_d;
    logic        deliver, squash, idle_load;
    logic [15:0] dlv_instr;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        npc_d     = npc_q;
        skid_d    = skid_q;
        err_d     = err_q | (doBranch & branchPc[0]);
        deliver   = 1'b0;
        squash    = 1'b0;
        idle_load = 1'b0;
        dlv_instr = imemData;
        imemRd    = 1'b0;
        memStall  = 1'b0;

        case (state_q)
            S_FETCH: begin
                imemRd   = ~hazStall & ~haltIn & ~doBranch & ~imemStall;
                memStall = (imemRd & ~imemDone) | imemStall;
                if (doBranch) begin
                    pc_d   = branchPc;
                    squash = 1'b1;
                end else if (haltIn) begin
                    state_d   = S_HALTED;
                    idle_load = 1'b1;
                end else if (imemRd) begin
                    if (imemDone) deliver = 1'b1;
                    else begin
                        state_d = S_WAIT;
                        squash  = 1'b1;
                    end
                end else begin
                    idle_load = 1'b1;
                end
            end
            S_WAIT: begin
                memStall = 1'b1;
                // halt is deferred here; it is honoured on the next FETCH
                if (doBranch) begin
                    pc_d    = branchPc;
                    squash  = 1'b1;
                    state_d = imemDone ? S_FETCH : S_DRAIN;
                end else if (imemDone) begin
                    if (hazStall) begin
                        skid_d  = imemData;
                        state_d = S_SKID;
                    end else begin
                        deliver = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    idle_load = 1'b1;
                end
            end
            S_SKID: begin
                if (doBranch) begin
                    pc_d    = branchPc;
                    squash  = 1'b1;
                    state_d = S_FETCH;
                end else if (!hazStall) begin
                    deliver   = 1'b1;
                    dlv_instr = skid_q;
                    state_d   = S_FETCH;
                end
            end
            S_DRAIN: begin
                memStall = 1'b1;
                if (doBranch) begin
                    pc_d   = branchPc;
                    squash = 1'b1;
                end else begin
                    idle_load = 1'b1;
                end
                if (imemDone) state_d = S_FETCH;
            end
            S_HALTED: begin
                if (doBranch) begin
                    pc_d    = branchPc;
                    squash  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    idle_load = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (deliver) begin
            instr_d = dlv_instr;
            npc_d   = pc_q + 16'd2;
            pc_d    = pc_q + 16'd2;
        end else if (squash || (idle_load && !hazStall)) begin
            instr_d = NOP_INSTR;
            npc_d   = 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            npc_q   <= 16'h0000;
            skid_q  <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            skid_q  <= skid_d;
            err_q   <= err_d;
        end
    end

    assign imemAddr  = pc_q;
    assign instrOut  = instr_q;
    assign nextPcOut = npc_q;
    assign err       = err_q;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (memStall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= 16'h0000;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, and
// randomized traffic checked against a transaction-level model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazStall, doBranch, haltIn, imemDone, imemStall;
    logic [15:0] branchPc, imemData;
    logic [15:0] imemAddr, instrOut, nextPcOut;
    logic        imemRd, memStall, err;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stallCnt;
`endif

    int ncmp = 0;
    int nerr = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .hazStall(hazStall), .doBranch(doBranch),
        .branchPc(branchPc), .haltIn(haltIn), .imemData(imemData),
        .imemDone(imemDone), .imemStall(imemStall), .imemAddr(imemAddr),
        .imemRd(imemRd), .instrOut(instrOut), .nextPcOut(nextPcOut),
        .memStall(memStall), .err(err)
`ifdef FETCH_STALL_CNT_EN
        , .stallCnt(stallCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        haz, br;
        logic [15:0] bpc;
        logic        halt;
        logic [15:0] data;
        logic        done, imst;
        logic [15:0] e_addr;
        logic        e_rd, e_ms;
        logic [15:0] e_instr, e_npc;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(logic haz, logic br, logic [15:0] bpc, logic halt,
                                logic [15:0] data, logic done, logic imst,
                                logic [15:0] ea, logic erd, logic ems,
                                logic [15:0] ei, logic [15:0] en, logic ee);
        vec_t v;
        v.haz = haz; v.br = br; v.bpc = bpc; v.halt = halt; v.data = data;
        v.done = done; v.imst = imst; v.e_addr = ea; v.e_rd = erd; v.e_ms = ems;
        v.e_instr = ei; v.e_npc = en; v.e_err = ee;
        return v;
    endfunction

    // Reference model: transaction view (outstanding read, discard pending,
    // held skid word, halted) rather than a named-state machine.
    logic [15:0] m_pc, m_instr, m_npc, m_skd, m_cnt;
    logic        m_err, m_out, m_drain, m_skv, m_halted;

    task automatic m_reset();
        m_pc = 16'h0000; m_instr = 16'h0800; m_npc = 16'h0000; m_skd = 16'h0000;
        m_cnt = 16'h0000; m_err = 1'b0; m_out = 1'b0; m_drain = 1'b0;
        m_skv = 1'b0; m_halted = 1'b0;
    endtask

    function automatic logic m_idle();
        return !m_out && !m_skv && !m_halted;
    endfunction

    function automatic logic m_rd();
        return m_idle() && !hazStall && !haltIn && !doBranch && !imemStall;
    endfunction

    function automatic logic m_ms();
        return (m_idle() && ((m_rd() && !imemDone) || imemStall)) || m_out;
    endfunction

    // Applied with the pre-edge inputs, once per rising edge.
    task automatic m_step();
        logic        dlv, bub, rd;
        logic [15:0] word;
        dlv = 1'b0; bub = 1'b0; word = imemData;
        rd = m_rd();
        if (m_ms() && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (doBranch) begin
            if (branchPc[0]) m_err = 1'b1;
            m_pc = branchPc;
            bub = 1'b1;
            if (m_out && !imemDone) m_drain = 1'b1;
            else begin m_out = 1'b0; m_drain = 1'b0; end
            m_skv = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            bub = !hazStall;
        end else if (m_skv) begin
            if (!hazStall) begin dlv = 1'b1; word = m_skd; m_skv = 1'b0; end
        end else if (m_out) begin
            if (imemDone) begin
                m_out = 1'b0;
                if (m_drain) begin m_drain = 1'b0; bub = !hazStall; end
                else if (hazStall) begin m_skv = 1'b1; m_skd = imemData; end
                else dlv = 1'b1;
            end else bub = !hazStall;
        end else if (haltIn) begin
            m_halted = 1'b1; bub = !hazStall;
        end else if (rd) begin
            if (imemDone) dlv = 1'b1;
            else begin m_out = 1'b1; bub = 1'b1; end
        end else bub = !hazStall;
        if (dlv) begin
            m_instr = word; m_npc = m_pc + 16'd2; m_pc = m_pc + 16'd2;
        end else if (bub) begin
            m_instr = 16'h0800; m_npc = 16'h0000;
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        hazStall = v.haz; doBranch = v.br; branchPc = v.bpc; haltIn = v.halt;
        imemData = v.data; imemDone = v.done; imemStall = v.imst;
        #1;
        chk($sformatf("vec%0d addr/rd/ms", idx), {imemAddr, imemRd, memStall},
            {v.e_addr, v.e_rd, v.e_ms});
        @(posedge clk); #1;
        chk($sformatf("vec%0d instr/npc/err", idx), {instrOut, nextPcOut, err},
            {v.e_instr, v.e_npc, v.e_err});
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hazStall = 0; doBranch = 0; branchPc = 0; haltIn = 0;
        imemData = 0; imemDone = 0; imemStall = 0;
    endtask

    vec_t tbl[24];

    initial begin
        tbl[0]  = mk(0,0,16'h0000,0,16'hA001,1,0, 16'h0000,1,0, 16'hA001,16'h0002,0);
        tbl[1]  = mk(0,0,16'h0000,0,16'hA002,1,0, 16'h0002,1,0, 16'hA002,16'h0004,0);
        tbl[2]  = mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0004,1,1, 16'h0800,16'h0000,0);
        tbl[3]  = mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0004,0,1, 16'h0800,16'h0000,0);
        tbl[4]  = mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0004,0,1, 16'h0800,16'h0000,0);
        tbl[5]  = mk(0,0,16'h0000,0,16'hA003,1,0, 16'h0004,0,1, 16'hA003,16'h0006,0);
        tbl[6]  = mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0006,1,1, 16'h0800,16'h0000,0);
        tbl[7]  = mk(1,0,16'h0000,0,16'hBEEF,1,0, 16'h0006,0,1, 16'h0800,16'h0000,0);
        tbl[8]  = mk(1,0,16'h0000,0,16'h0000,0,0, 16'h0006,0,0, 16'h0800,16'h0000,0);
        tbl[9]  = mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0006,0,0, 16'hBEEF,16'h0008,0);
        tbl[10] = mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0008,1,1, 16'h0800,16'h0000,0);
        tbl[11] = mk(0,1,16'h0040,0,16'h0000,0,0, 16'h0008,0,1, 16'h0800,16'h0000,0);
        tbl[12] = mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0040,0,1, 16'h0800,16'h0000,0);
        tbl[13] = mk(0,0,16'h0000,0,16'hDEAD,1,0, 16'h0040,0,1, 16'h0800,16'h0000,0);
        tbl[14] = mk(0,0,16'h0000,0,16'hC001,1,0, 16'h0040,1,0, 16'hC001,16'h0042,0);
        tbl[15] = mk(0,0,16'h0000,0,16'h0000,0,1, 16'h0042,0,1, 16'h0800,16'h0000,0);
        tbl[16] = mk(0,0,16'h0000,1,16'h0000,0,0, 16'h0042,0,0, 16'h0800,16'h0000,0);
        tbl[17] = mk(0,0,16'h0000,0,16'h1111,1,0, 16'h0042,0,0, 16'h0800,16'h0000,0);
        tbl[18] = mk(0,1,16'h0041,0,16'h0000,0,0, 16'h0042,0,0, 16'h0800,16'h0000,1);
        tbl[19] = mk(0,1,16'hFFFE,0,16'h0000,0,0, 16'h0041,0,0, 16'h0800,16'h0000,1);
        tbl[20] = mk(0,0,16'h0000,0,16'h2222,1,0, 16'hFFFE,1,0, 16'h2222,16'h0000,1);
        tbl[21] = mk(1,0,16'h0000,0,16'h0000,1,0, 16'h0000,0,0, 16'h2222,16'h0000,1);
        tbl[22] = mk(1,1,16'h0010,0,16'h0000,0,0, 16'h0000,0,0, 16'h0800,16'h0000,1);
        tbl[23] = mk(0,0,16'h0000,0,16'h3333,1,0, 16'h0010,1,0, 16'h3333,16'h0012,1);

        idle_inputs();
        rst = 1'b1;
        #1;
        chk("reset instr/npc/err/addr", {instrOut, nextPcOut, err, imemAddr},
            {16'h0800, 16'h0000, 1'b0, 16'h0000});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) apply_vec(tbl[i], i);

        // Park in WAIT at PC=0x12, then pulse reset between clock edges.
        idle_inputs();
        #1;
        chk("pre-reset miss rd/ms", {imemRd, memStall}, 2'b11);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async reset instr/npc/err/addr", {instrOut, nextPcOut, err, imemAddr},
            {16'h0800, 16'h0000, 1'b0, 16'h0000});
`ifdef FETCH_STALL_CNT_EN
        chk("async reset stallCnt", stallCnt, 16'h0000);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-reset rd/ms", {imemRd, memStall}, 2'b11);
        @(negedge clk);

        // Randomized traffic against the model, with occasional resets.
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                m_reset();
                #1;
                chk("rand reset", {instrOut, nextPcOut, err, imemAddr},
                    {m_instr, m_npc, m_err, m_pc});
                @(negedge clk);
                rst = 1'b0;
            end
            hazStall  = ($urandom_range(0, 3) == 0);
            doBranch  = ($urandom_range(0, 11) == 0);
            branchPc  = 16'($urandom_range(0, 65535)) & (($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'hFFFE);
            haltIn    = ($urandom_range(0, 24) == 0);
            imemData  = 16'($urandom_range(0, 65535));
            imemDone  = ($urandom_range(0, 1) == 1);
            imemStall = ($urandom_range(0, 6) == 0);
            #1;
            chk($sformatf("rand%0d addr/rd/ms", c), {imemAddr, imemRd, memStall},
                {m_pc, m_rd(), m_ms()});
            @(posedge clk);
            m_step();
            #1;
            chk($sformatf("rand%0d instr/npc/err", c), {instrOut, nextPcOut, err},
                {m_instr, m_npc, m_err});
`ifdef FETCH_STALL_CNT_EN
            chk($sformatf("rand%0d stallCnt", c), stallCnt, m_cnt);
`endif
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
